// File: rtl/reorder_buffer_if.sv
// Dispatch/writeback/commit bundle between the reorder buffer and its neighbours.
// Query ports exist only when ROB_OPERAND_QUERY_EN is defined.
interface reorder_buffer_if #(
  parameter int TAG_W = 4
);
  logic             rdy;
  logic             alloc_valid;
  logic             alloc_has_rd;
  logic [4:0]       alloc_rd;
  logic             alloc_done;
  logic [31:0]      alloc_value;
  logic [TAG_W-1:0] alloc_tag;
  logic             rob_full;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_value;
  logic             wb_mispredict;
  logic [31:0]      wb_redirect_pc;
  logic             register_update_flag;
  logic [4:0]       register_commit_dest;
  logic [31:0]      register_commit_value;
  logic [TAG_W-1:0] rename_of_commit_ins;
  logic             register_flush;
  logic [31:0]      flush_pc;
`ifdef ROB_OPERAND_QUERY_EN
  logic [TAG_W-1:0] query_tag_a;
  logic [TAG_W-1:0] query_tag_b;
  logic             query_ready_a;
  logic             query_ready_b;
  logic [31:0]      query_value_a;
  logic [31:0]      query_value_b;
`endif

  // Dispatch / execution side
  modport master (
    output rdy, alloc_valid, alloc_has_rd, alloc_rd, alloc_done, alloc_value,
    output wb_valid, wb_tag, wb_value, wb_mispredict, wb_redirect_pc,
    input  alloc_tag, rob_full,
    input  register_update_flag, register_commit_dest, register_commit_value,
    input  rename_of_commit_ins, register_flush, flush_pc
`ifdef ROB_OPERAND_QUERY_EN
    , output query_tag_a, query_tag_b
    , input  query_ready_a, query_ready_b, query_value_a, query_value_b
`endif
  );

  // Reorder buffer side
  modport slave (
    input  rdy, alloc_valid, alloc_has_rd, alloc_rd, alloc_done, alloc_value,
    input  wb_valid, wb_tag, wb_value, wb_mispredict, wb_redirect_pc,
    output alloc_tag, rob_full,
    output register_update_flag, register_commit_dest, register_commit_value,
    output rename_of_commit_ins, register_flush, flush_pc
`ifdef ROB_OPERAND_QUERY_EN
    , input  query_tag_a, query_tag_b
    , output query_ready_a, query_ready_b, query_value_a, query_value_b
`endif
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates rename tags, records results, retires one entry per cycle.
// Optional operand lookup ports are enabled with `define ROB_OPERAND_QUERY_EN.
module reorder_buffer #(
  parameter int TAG_W = 4
) (
  input logic            clk,
  input logic            rst,
  reorder_buffer_if.slave rob
);
  localparam int DEPTH = 1 << TAG_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] hasRd_q;
  logic [DEPTH-1:0] mispredict_q;
  logic [4:0]       rd_q         [DEPTH];
  logic [31:0]      value_q      [DEPTH];
  logic [31:0]      redirectPc_q [DEPTH];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic             updateFlag_q;
  logic [4:0]       commitDest_q;
  logic [31:0]      commitValue_q;
  logic [TAG_W-1:0] commitTag_q;
  logic             flush_q;
  logic [31:0]      flushPc_q;

  logic full, headReady, flushNow, commitNow, allocFire, wbFire;

  // A mispredicted head flushes instead of retiring, and swallows that cycle's alloc and wb.
  assign full      = (count_q == (TAG_W+1)'(DEPTH));
  assign headReady = busy_q[head_q] && done_q[head_q];
  assign flushNow  = rob.rdy && headReady && mispredict_q[head_q];
  assign commitNow = rob.rdy && headReady && !mispredict_q[head_q];
  assign allocFire = rob.rdy && rob.alloc_valid && !full && !flushNow;
  assign wbFire    = rob.rdy && rob.wb_valid && busy_q[rob.wb_tag] && !flushNow;

  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flushNow) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wbFire) done_d[rob.wb_tag] = 1'b1;
      if (commitNow) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + TAG_W'(1);
      end
      if (allocFire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = rob.alloc_done;
        tail_d         = tail_q + TAG_W'(1);
      end
      count_d = count_q + (TAG_W+1)'(allocFire) - (TAG_W+1)'(commitNow);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload fields; validity is tracked solely by busy/done above.
  always_ff @(posedge clk) begin
    if (rst) begin
      hasRd_q      <= '0;
      mispredict_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]         <= '0;
        value_q[i]      <= '0;
        redirectPc_q[i] <= '0;
      end
    end else begin
      if (allocFire) begin
        hasRd_q[tail_q]      <= rob.alloc_has_rd;
        rd_q[tail_q]         <= rob.alloc_rd;
        value_q[tail_q]      <= rob.alloc_done ? rob.alloc_value : 32'd0;
        mispredict_q[tail_q] <= 1'b0;
        redirectPc_q[tail_q] <= '0;
      end
      if (wbFire) begin
        value_q[rob.wb_tag]      <= rob.wb_value;
        mispredict_q[rob.wb_tag] <= rob.wb_mispredict;
        redirectPc_q[rob.wb_tag] <= rob.wb_redirect_pc;
      end
    end
  end

  // Pulses are recomputed only while rdy is high, so a stall freezes them as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      updateFlag_q  <= 1'b0;
      commitDest_q  <= '0;
      commitValue_q <= '0;
      commitTag_q   <= '0;
      flush_q       <= 1'b0;
      flushPc_q     <= '0;
    end else if (rob.rdy) begin
      updateFlag_q <= commitNow && hasRd_q[head_q];
      flush_q      <= flushNow;
      if (commitNow) begin
        commitDest_q  <= rd_q[head_q];
        commitValue_q <= value_q[head_q];
        commitTag_q   <= head_q;
      end
      if (flushNow) flushPc_q <= redirectPc_q[head_q];
    end
  end

  assign rob.alloc_tag             = tail_q;
  assign rob.rob_full              = full;
  assign rob.register_update_flag  = updateFlag_q;
  assign rob.register_commit_dest  = commitDest_q;
  assign rob.register_commit_value = commitValue_q;
  assign rob.rename_of_commit_ins  = commitTag_q;
  assign rob.register_flush        = flush_q;
  assign rob.flush_pc              = flushPc_q;

`ifdef ROB_OPERAND_QUERY_EN
  logic wbHitA, wbHitB;
  assign wbHitA            = rob.wb_valid && (rob.wb_tag == rob.query_tag_a);
  assign wbHitB            = rob.wb_valid && (rob.wb_tag == rob.query_tag_b);
  assign rob.query_ready_a = busy_q[rob.query_tag_a] && (done_q[rob.query_tag_a] || wbHitA);
  assign rob.query_ready_b = busy_q[rob.query_tag_b] && (done_q[rob.query_tag_b] || wbHitB);
  assign rob.query_value_a = wbHitA ? rob.wb_value : value_q[rob.query_tag_a];
  assign rob.query_value_b = wbHitB ? rob.wb_value : value_q[rob.query_tag_b];
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer; query scenario runs only with ROB_OPERAND_QUERY_EN.
module tb_reorder_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  reorder_buffer_if #(.TAG_W(4)) robIf ();

  reorder_buffer #(.TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .rob (robIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    robIf.rdy            = 1'b1;
    robIf.alloc_valid    = 1'b0;
    robIf.alloc_has_rd   = 1'b0;
    robIf.alloc_rd       = '0;
    robIf.alloc_done     = 1'b0;
    robIf.alloc_value    = '0;
    robIf.wb_valid       = 1'b0;
    robIf.wb_tag         = '0;
    robIf.wb_value       = '0;
    robIf.wb_mispredict  = 1'b0;
    robIf.wb_redirect_pc = '0;
`ifdef ROB_OPERAND_QUERY_EN
    robIf.query_tag_a    = '0;
    robIf.query_tag_b    = '0;
`endif
  endtask

  task automatic applyReset();
    clearInputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic setAlloc(input logic hasRd, input logic [4:0] rd, input logic done,
                          input logic [31:0] value);
    robIf.alloc_valid  = 1'b1;
    robIf.alloc_has_rd = hasRd;
    robIf.alloc_rd     = rd;
    robIf.alloc_done   = done;
    robIf.alloc_value  = value;
  endtask

  task automatic setWb(input logic [3:0] tag, input logic [31:0] value, input logic mis,
                       input logic [31:0] pc);
    robIf.wb_valid       = 1'b1;
    robIf.wb_tag         = tag;
    robIf.wb_value       = value;
    robIf.wb_mispredict  = mis;
    robIf.wb_redirect_pc = pc;
  endtask

  task automatic test_reset();
    applyReset();
    checks++; if (robIf.register_update_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_flag: got %b expected 0", robIf.register_update_flag); end
    checks++; if (robIf.register_flush !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush: got %b expected 0", robIf.register_flush); end
    checks++; if (robIf.alloc_tag !== 4'd0) begin failures++; $display("[TB] FAIL reset_tag: got %0d expected 0", robIf.alloc_tag); end
    checks++; if (robIf.rob_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %b expected 0", robIf.rob_full); end
    checks++; if (robIf.flush_pc !== 32'd0 || robIf.register_commit_value !== 32'd0) begin failures++; $display("[TB] FAIL reset_regs: got pc %h value %h expected 0 0", robIf.flush_pc, robIf.register_commit_value); end
  endtask

  task automatic test_basic_commit();
    applyReset();
    setAlloc(1'b1, 5'd5, 1'b0, 32'd0);
    tick();
    clearInputs();
    setWb(4'd0, 32'h1234, 1'b0, 32'd0);
    tick();
    clearInputs();
    checks++; if (robIf.register_update_flag !== 1'b0) begin failures++; $display("[TB] FAIL basic_early: got %b expected 0", robIf.register_update_flag); end
    tick();
    checks++; if (robIf.register_update_flag !== 1'b1) begin failures++; $display("[TB] FAIL basic_flag: got %b expected 1", robIf.register_update_flag); end
    checks++; if (robIf.register_commit_dest !== 5'd5) begin failures++; $display("[TB] FAIL basic_dest: got %0d expected 5", robIf.register_commit_dest); end
    checks++; if (robIf.register_commit_value !== 32'h1234) begin failures++; $display("[TB] FAIL basic_value: got %h expected 1234", robIf.register_commit_value); end
    checks++; if (robIf.rename_of_commit_ins !== 4'd0) begin failures++; $display("[TB] FAIL basic_tag: got %0d expected 0", robIf.rename_of_commit_ins); end
    tick();
    checks++; if (robIf.register_update_flag !== 1'b0) begin failures++; $display("[TB] FAIL basic_pulse: got %b expected 0", robIf.register_update_flag); end
    checks++; if (robIf.alloc_tag !== 4'd1) begin failures++; $display("[TB] FAIL basic_next_tag: got %0d expected 1", robIf.alloc_tag); end
  endtask

  task automatic test_full_wrap();
    applyReset();
    for (int i = 0; i < 16; i++) begin
      setAlloc(1'b1, 5'(i), 1'b0, 32'd0);
      tick();
    end
    checks++; if (robIf.rob_full !== 1'b1) begin failures++; $display("[TB] FAIL full_set: got %b expected 1", robIf.rob_full); end
    setAlloc(1'b1, 5'd17, 1'b0, 32'd0);
    tick();
    checks++; if (robIf.alloc_tag !== 4'd0) begin failures++; $display("[TB] FAIL full_17th: got tag %0d expected 0", robIf.alloc_tag); end
    clearInputs();
    setWb(4'd0, 32'h55, 1'b0, 32'd0);
    tick();
    clearInputs();
    setAlloc(1'b1, 5'd20, 1'b0, 32'd0);
    tick();
    checks++; if (robIf.register_update_flag !== 1'b1 || robIf.register_commit_dest !== 5'd0 || robIf.register_commit_value !== 32'h55) begin failures++; $display("[TB] FAIL full_commit: got flag %b dest %0d value %h expected 1 0 55", robIf.register_update_flag, robIf.register_commit_dest, robIf.register_commit_value); end
    checks++; if (robIf.rob_full !== 1'b0 || robIf.alloc_tag !== 4'd0) begin failures++; $display("[TB] FAIL full_no_alloc_on_commit: got full %b tag %0d expected 0 0", robIf.rob_full, robIf.alloc_tag); end
    tick();
    clearInputs();
    checks++; if (robIf.alloc_tag !== 4'd1 || robIf.rob_full !== 1'b1) begin failures++; $display("[TB] FAIL wrap_alloc: got tag %0d full %b expected 1 1", robIf.alloc_tag, robIf.rob_full); end
  endtask

  task automatic test_out_of_order_wb();
    applyReset();
    setAlloc(1'b1, 5'd1, 1'b0, 32'd0);
    tick();
    setAlloc(1'b1, 5'd2, 1'b0, 32'd0);
    tick();
    clearInputs();
    setWb(4'd1, 32'hB, 1'b0, 32'd0);
    tick();
    clearInputs();
    tick();
    checks++; if (robIf.register_update_flag !== 1'b0) begin failures++; $display("[TB] FAIL ooo_hold: got %b expected 0", robIf.register_update_flag); end
    setWb(4'd0, 32'hA, 1'b0, 32'd0);
    tick();
    clearInputs();
    tick();
    checks++; if (robIf.register_update_flag !== 1'b1 || robIf.rename_of_commit_ins !== 4'd0 || robIf.register_commit_dest !== 5'd1 || robIf.register_commit_value !== 32'hA) begin failures++; $display("[TB] FAIL ooo_first: got flag %b tag %0d dest %0d value %h expected 1 0 1 a", robIf.register_update_flag, robIf.rename_of_commit_ins, robIf.register_commit_dest, robIf.register_commit_value); end
    tick();
    checks++; if (robIf.register_update_flag !== 1'b1 || robIf.rename_of_commit_ins !== 4'd1 || robIf.register_commit_dest !== 5'd2 || robIf.register_commit_value !== 32'hB) begin failures++; $display("[TB] FAIL ooo_second: got flag %b tag %0d dest %0d value %h expected 1 1 2 b", robIf.register_update_flag, robIf.rename_of_commit_ins, robIf.register_commit_dest, robIf.register_commit_value); end
    tick();
    checks++; if (robIf.register_update_flag !== 1'b0) begin failures++; $display("[TB] FAIL ooo_idle: got %b expected 0", robIf.register_update_flag); end
  endtask

  task automatic test_mispredict_flush();
    applyReset();
    setAlloc(1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    for (int i = 1; i < 4; i++) begin
      setAlloc(1'b1, 5'(9 + i), 1'b0, 32'd0);
      tick();
    end
    clearInputs();
    setWb(4'd0, 32'd0, 1'b1, 32'h100);
    tick();
    setAlloc(1'b1, 5'd4, 1'b1, 32'h44);
    setWb(4'd1, 32'h11, 1'b0, 32'd0);
    tick();
    clearInputs();
    checks++; if (robIf.register_flush !== 1'b1 || robIf.flush_pc !== 32'h100) begin failures++; $display("[TB] FAIL flush_pulse: got flush %b pc %h expected 1 100", robIf.register_flush, robIf.flush_pc); end
    checks++; if (robIf.register_update_flag !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_commit: got %b expected 0", robIf.register_update_flag); end
    checks++; if (robIf.alloc_tag !== 4'd0 || robIf.rob_full !== 1'b0) begin failures++; $display("[TB] FAIL flush_reset_ptr: got tag %0d full %b expected 0 0", robIf.alloc_tag, robIf.rob_full); end
    tick();
    checks++; if (robIf.register_flush !== 1'b0 || robIf.register_update_flag !== 1'b0) begin failures++; $display("[TB] FAIL flush_one_cycle: got flush %b flag %b expected 0 0", robIf.register_flush, robIf.register_update_flag); end
    setAlloc(1'b1, 5'd3, 1'b1, 32'h77);
    tick();
    clearInputs();
    tick();
    checks++; if (robIf.register_update_flag !== 1'b1 || robIf.rename_of_commit_ins !== 4'd0 || robIf.register_commit_value !== 32'h77) begin failures++; $display("[TB] FAIL flush_restart: got flag %b tag %0d value %h expected 1 0 77", robIf.register_update_flag, robIf.rename_of_commit_ins, robIf.register_commit_value); end
  endtask

  task automatic test_silent_retire();
    applyReset();
    setAlloc(1'b0, 5'd9, 1'b1, 32'h5);
    tick();
    clearInputs();
    tick();
    checks++; if (robIf.register_update_flag !== 1'b0 || robIf.alloc_tag !== 4'd1) begin failures++; $display("[TB] FAIL silent_retire: got flag %b tag %0d expected 0 1", robIf.register_update_flag, robIf.alloc_tag); end
  endtask

  task automatic test_rdy_stall();
    applyReset();
    setAlloc(1'b1, 5'd7, 1'b1, 32'hAB);
    tick();
    clearInputs();
    robIf.rdy = 1'b0;
    setAlloc(1'b1, 5'd8, 1'b1, 32'hCD);
    tick();
    tick();
    checks++; if (robIf.register_update_flag !== 1'b0 || robIf.alloc_tag !== 4'd1) begin failures++; $display("[TB] FAIL stall_hold: got flag %b tag %0d expected 0 1", robIf.register_update_flag, robIf.alloc_tag); end
    clearInputs();
    tick();
    checks++; if (robIf.register_update_flag !== 1'b1 || robIf.register_commit_dest !== 5'd7 || robIf.register_commit_value !== 32'hAB) begin failures++; $display("[TB] FAIL stall_release: got flag %b dest %0d value %h expected 1 7 ab", robIf.register_update_flag, robIf.register_commit_dest, robIf.register_commit_value); end
    robIf.rdy = 1'b0;
    tick();
    checks++; if (robIf.register_update_flag !== 1'b1) begin failures++; $display("[TB] FAIL stall_pulse_hold: got %b expected 1", robIf.register_update_flag); end
    robIf.rdy = 1'b1;
    tick();
    checks++; if (robIf.register_update_flag !== 1'b0) begin failures++; $display("[TB] FAIL stall_pulse_end: got %b expected 0", robIf.register_update_flag); end
  endtask

  task automatic test_mid_reset();
    applyReset();
    setAlloc(1'b1, 5'd6, 1'b1, 32'h66);
    tick();
    clearInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (robIf.register_update_flag !== 1'b0 || robIf.alloc_tag !== 4'd0) begin failures++; $display("[TB] FAIL midreset: got flag %b tag %0d expected 0 0", robIf.register_update_flag, robIf.alloc_tag); end
  endtask

`ifdef ROB_OPERAND_QUERY_EN
  task automatic test_operand_query();
    applyReset();
    for (int i = 0; i < 4; i++) begin
      setAlloc(1'b1, 5'(i + 1), 1'b0, 32'd0);
      tick();
    end
    clearInputs();
    robIf.query_tag_a = 4'd3;
    robIf.query_tag_b = 4'd2;
    setWb(4'd3, 32'd9, 1'b0, 32'd0);
    #1;
    checks++; if (robIf.query_ready_a !== 1'b1 || robIf.query_value_a !== 32'd9) begin failures++; $display("[TB] FAIL query_fwd: got ready %b value %h expected 1 9", robIf.query_ready_a, robIf.query_value_a); end
    checks++; if (robIf.query_ready_b !== 1'b0) begin failures++; $display("[TB] FAIL query_pending: got %b expected 0", robIf.query_ready_b); end
    tick();
    clearInputs();
    robIf.query_tag_b = 4'd3;
    #1;
    checks++; if (robIf.query_ready_b !== 1'b1 || robIf.query_value_b !== 32'd9) begin failures++; $display("[TB] FAIL query_stored: got ready %b value %h expected 1 9", robIf.query_ready_b, robIf.query_value_b); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clearInputs();
    test_reset();
    test_basic_commit();
    test_full_wrap();
    test_out_of_order_wb();
    test_mispredict_flush();
    test_silent_retire();
    test_rdy_stall();
    test_mid_reset();
`ifdef ROB_OPERAND_QUERY_EN
    test_operand_query();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
